wave_capture: RTL and testbench
===============================

WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 The block SHALL have parameter SAMPLE_BITS, default 8, giving log2 of the samples captured per frame (256).
REQ-002 The block SHALL have parameter IN_WIDTH, default 16, giving the width of the incoming signed audio sample.
REQ-003 The block SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port new_sample_ready, input, 1: one-cycle strobe qualifying new_sample_in.
REQ-006 The block SHALL have port new_sample_in, input, IN_WIDTH: two's-complement audio sample.
REQ-007 The block SHALL have port wave_display_idle, input, 1: high while the display is outside the active region, so a buffer swap is safe.
REQ-008 The block SHALL have port write_address, output, SAMPLE_BITS+1: sample-RAM write address, {buffer select, sample index}.
REQ-009 The block SHALL have port write_enable, output, 1: sample-RAM write strobe.
REQ-010 The block SHALL have port write_sample, output, 8: offset-binary sample to store.
REQ-011 The block SHALL have port read_index, output, 1: which RAM half the display reads; the capture block always writes the other half.

Function
REQ-012 The block SHALL implement the states ARMED, ACTIVE and WAIT.
REQ-013 The block SHALL keep prev_sample, updated from new_sample_in on every new_sample_ready in every state.
REQ-014 In ARMED, the block SHALL trigger on a strobe where prev_sample MSB=1 and new_sample_in MSB=0 (positive zero crossing; 0 counts as non-negative), and SHALL then enter ACTIVE with the triggering sample written at index 0.
REQ-015 In ACTIVE, the block SHALL write each strobed sample at the current index and then increment the index; after the write at index 255 it SHALL enter WAIT.
REQ-016 Write outputs SHALL be registered: write_enable is high for exactly the one cycle after each accepted strobe, and is never high in any other cycle.
REQ-017 write_address SHALL equal {~read_index, index} as sampled at the accepted strobe.
REQ-018 write_sample SHALL equal new_sample_in[IN_WIDTH-1:IN_WIDTH-8] with the MSB inverted (signed to offset binary: 0x80 maps to 0x00, 0x7F maps to 0xFF).
REQ-019 In WAIT, strobes SHALL cause no writes; on the first cycle with wave_display_idle=1, the block SHALL toggle read_index, clear the index and enter ARMED, all in that one cycle.
REQ-020 If wave_display_idle is already high on WAIT entry, the swap SHALL occur on the next cycle.
REQ-021 A strobe in the same cycle as the WAIT-to-ARMED transition SHALL update prev_sample but SHALL NOT be evaluated for trigger.
REQ-022 Strobes on consecutive cycles SHALL each be accepted, giving back-to-back one-cycle write pulses.

Reset
REQ-023 On reset, the block SHALL set state=ARMED, index=0, read_index=0, prev_sample=0, write_enable=0, write_address=0 and write_sample=0.
REQ-024 Reset SHALL take priority over every event in the same cycle, including a strobe; reset mid-capture SHALL abandon the partial frame without a swap.

Structure
REQ-025 The state enumeration and the SAMPLE_BITS and IN_WIDTH defaults SHALL live in the shared synth package.
REQ-026 No sub-module is required; the block SHALL be a single FSM plus counter and registers.

Verification
REQ-027 The bench SHALL cover trigger and capture: samples -5, +3, then 255 further strobes, with idle=0 -> 256 writes at addresses 256..511 (read_index=0 so writes go to the upper half); first write_sample is 0x80 (+3 upper byte is 0x00 inverted); state then WAIT with no further writes.
REQ-028 The bench SHALL cover no trigger: strobes with monotonic positive values -> zero write_enable pulses and state stays ARMED.
REQ-029 The bench SHALL cover the swap: after a full capture, idle rises -> read_index becomes 1 one cycle later, and the next capture writes addresses 0..255.
REQ-030 The bench SHALL cover back-to-back strobes: strobe every cycle during ACTIVE -> 256 consecutive write pulses, addresses incrementing by 1.
REQ-031 The bench SHALL cover mid-capture reset: reset asserted at index 100 -> next cycle read_index=0, write_enable=0, state ARMED; no write occurs in the reset cycle.
REQ-032 The bench SHALL cover value mapping: strobe inputs 0x8000, 0x0000 and 0x7FFF -> write_sample 0x00, 0x80 and 0xFF.

Source files
------------

// File: rtl/wave_capture_pkg.sv
// Shared definitions for the waveform capture block: parameter defaults and FSM states.
package wave_capture_pkg;

  localparam int SAMPLE_BITS_DEFAULT = 8;
  localparam int IN_WIDTH_DEFAULT    = 16;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/wave_capture.sv
// Captures one frame of audio samples, starting at a positive zero crossing, into the RAM half
// the display is not reading; the halves are swapped once the display goes idle.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
  parameter int IN_WIDTH    = IN_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_sample_ready,
  input  logic [IN_WIDTH-1:0]  new_sample_in,
  input  logic                 wave_display_idle,
  output logic [SAMPLE_BITS:0] write_address,
  output logic                 write_enable,
  output logic [7:0]           write_sample,
  output logic                 read_index
);

  localparam logic [SAMPLE_BITS-1:0] LAST_IDX = '1;

  cap_state_e             state_q, state_d;
  logic [SAMPLE_BITS-1:0] index_q, index_d;
  logic                   read_index_q, read_index_d;
  logic [IN_WIDTH-1:0]    prev_q, prev_d;
  logic                   we_q, we_d;
  logic [SAMPLE_BITS:0]   addr_q, addr_d;
  logic [7:0]             ws_q, ws_d;
  logic                   trigger;
  logic                   accept;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    read_index_d = read_index_q;
    prev_d       = new_sample_ready ? new_sample_in : prev_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    ws_d         = ws_q;
    accept       = 1'b0;
    trigger      = new_sample_ready && prev_q[IN_WIDTH-1] && !new_sample_in[IN_WIDTH-1];

    case (state_q)
      ARMED: begin
        if (trigger) begin
          accept  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (new_sample_ready) begin
          accept = 1'b1;
          if (index_q == LAST_IDX) state_d = WAIT;
        end
      end
      WAIT: begin
        // A strobe landing on the swap cycle only refreshes prev_sample.
        if (wave_display_idle) begin
          read_index_d = ~read_index_q;
          index_d      = '0;
          state_d      = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase

    // Index wraps to zero after the last slot, leaving it clear for the next frame.
    if (accept) begin
      index_d = index_q + SAMPLE_BITS'(1);
      we_d    = 1'b1;
      addr_d  = {~read_index_q, index_q};
      ws_d    = {~new_sample_in[IN_WIDTH-1], new_sample_in[IN_WIDTH-2 -: 7]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARMED;
      index_q      <= '0;
      read_index_q <= 1'b0;
      prev_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      ws_q         <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      read_index_q <= read_index_d;
      prev_q       <= prev_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      ws_q         <= ws_d;
    end
  end

  assign write_address = addr_q;
  assign write_enable  = we_q;
  assign write_sample  = ws_q;
  assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: constant vector table, directed frame sequences and a
// randomized run, all compared against a behavioural frame-capture model.
module tb_wave_capture;
  import wave_capture_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = '0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  wave_capture dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model: a frame is 256 slots, written into the half opposite the display's.
  cap_state_e m_state = ARMED;
  int         m_idx   = 0;
  bit         m_rd    = 1'b0;
  int         m_prev  = 0;
  bit         m_we    = 1'b0;
  int         m_addr  = 0;
  int         m_ws    = 0;

  int obs_addr[$];
  int obs_ws[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    else n_pass++;
  endtask

  function automatic bit is_neg(input int v);
    return v >= 32768;
  endfunction

  task automatic model_edge(input bit r, input bit rdy, input int d, input bit idle);
    bit wr;
    wr = 1'b0;
    m_we = 1'b0;
    if (r) begin
      m_state = ARMED; m_idx = 0; m_rd = 1'b0; m_prev = 0; m_addr = 0; m_ws = 0;
      return;
    end
    if (m_state == ARMED && rdy && is_neg(m_prev) && !is_neg(d)) begin
      wr = 1'b1;
      m_state = ACTIVE;
    end else if (m_state == ACTIVE && rdy) begin
      wr = 1'b1;
    end else if (m_state == WAIT && idle) begin
      m_rd = !m_rd; m_idx = 0; m_state = ARMED;
    end
    if (wr) begin
      m_we   = 1'b1;
      m_addr = (m_rd ? 0 : 256) + m_idx;
      m_ws   = ((d / 256) + 128) % 256;
      m_idx  = m_idx + 1;
      if (m_idx == 256) begin
        m_idx = 0;
        m_state = WAIT;
      end
    end
    if (rdy) m_prev = d;
  endtask

  task automatic step(input bit r, input bit rdy, input logic [15:0] d, input bit idle);
    reset = r; new_sample_ready = rdy; new_sample_in = d; wave_display_idle = idle;
    @(posedge clk);
    model_edge(r, rdy, int'(d), idle);
    #1;
    chk("we",    int'(write_enable),  int'(m_we));
    chk("addr",  int'(write_address), m_addr);
    chk("ws",    int'(write_sample),  m_ws);
    chk("rdidx", int'(read_index),    int'(m_rd));
    chk("state", int'(dut.state_q),   int'(m_state));
    if (write_enable === 1'b1) begin
      obs_addr.push_back(int'(write_address));
      obs_ws.push_back(int'(write_sample));
    end
  endtask

  // Triggers (negative then non-negative) and writes the remaining 255 slots.
  task automatic capture_frame(input int gaps);
    step(0, 1, 16'h9000, 0);
    step(0, 1, 16'h0400, 0);
    for (int k = 0; k < 255; k++) begin
      for (int g = 0; g < gaps; g++) step(0, 0, 16'h0, 0);
      step(0, 1, 16'($urandom), 0);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [15:0] din;
    logic        idle;
    logic        we;
    logic [8:0]  addr;
    logic [7:0]  ws;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int ok;
    int b2b;

    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'd0,   8'h00};
    tbl[1] = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 9'd0,   8'h00};
    tbl[2] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 9'd256, 8'h80};
    tbl[3] = '{1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 9'd257, 8'hFF};
    tbl[4] = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 9'd258, 8'h00};
    tbl[5] = '{1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 9'd258, 8'h00};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].din, tbl[i].idle);
      chk($sformatf("tbl%0d_we", i),   int'(write_enable),  int'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i), int'(write_address), int'(tbl[i].addr));
      chk($sformatf("tbl%0d_ws", i),   int'(write_sample),  int'(tbl[i].ws));
    end

    // Monotonic positive input never crosses zero.
    step(1, 0, 16'h0, 0);
    obs_addr.delete();
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 16'(100 * k + 10), 0);
      step(0, 0, 16'h0, 0);
    end
    chk("notrig_writes", obs_addr.size(), 0);
    chk("notrig_state", int'(dut.state_q), int'(ARMED));

    // -5 then +3 triggers; frame lands in the upper half.
    step(1, 0, 16'h0, 0);
    obs_addr.delete(); obs_ws.delete();
    step(0, 1, 16'hFFFB, 0);
    step(0, 0, 16'h0, 0);
    step(0, 1, 16'h0003, 0);
    for (int k = 0; k < 255; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(0, 0, 16'h0, 0);
      step(0, 1, 16'($urandom), 0);
    end
    chk("cap_count", obs_addr.size(), 256);
    ok = 1;
    foreach (obs_addr[i]) if (obs_addr[i] != 256 + i) ok = 0;
    chk("cap_addr_seq", ok, 1);
    chk("cap_first_ws", obs_ws.size() > 0 ? obs_ws[0] : -1, 8'h80);
    for (int k = 0; k < 5; k++) step(0, 1, 16'($urandom), 0);
    chk("wait_no_writes", obs_addr.size(), 256);
    chk("wait_state", int'(dut.state_q), int'(WAIT));

    // Swap on idle, then a back-to-back capture into the lower half.
    step(0, 0, 16'h0, 1);
    chk("swap_rdidx", int'(read_index), 1);
    chk("swap_state", int'(dut.state_q), int'(ARMED));
    step(0, 0, 16'h0, 0);
    obs_addr.delete();
    step(0, 1, 16'hC000, 0);
    b2b = 0;
    for (int k = 0; k < 256; k++) begin
      step(0, 1, (k == 255) ? 16'h8000 : (k == 0 ? 16'h0100 : 16'($urandom)), k == 255);
      if (write_enable === 1'b1) b2b++;
    end
    chk("b2b_pulses", b2b, 256);
    ok = 1;
    foreach (obs_addr[i]) if (obs_addr[i] != i) ok = 0;
    chk("b2b_addr_seq", ok, 1);
    chk("b2b_count", obs_addr.size(), 256);
    chk("wait_entry_no_swap", int'(read_index), 1);
    // Idle already high on entry: swap now, with a would-be trigger strobe ignored.
    step(0, 1, 16'h0100, 1);
    chk("swap2_rdidx", int'(read_index), 0);
    chk("swap_cycle_no_write", int'(write_enable), 0);
    step(0, 1, 16'h0200, 0);
    chk("post_swap_no_trig", int'(write_enable), 0);
    chk("post_swap_state", int'(dut.state_q), int'(ARMED));

    // Abandon a partial frame with reset (and a strobe) at index 100.
    capture_frame(0);
    step(0, 0, 16'h0, 1);
    chk("pre_rst_rdidx", int'(read_index), 1);
    step(0, 0, 16'h0, 0);
    step(0, 1, 16'h9000, 0);
    step(0, 1, 16'h0400, 0);
    for (int k = 0; k < 99; k++) step(0, 1, 16'($urandom), 0);
    chk("pre_rst_index", int'(dut.index_q), 100);
    step(1, 1, 16'h1234, 1);
    chk("rst_we", int'(write_enable), 0);
    chk("rst_rdidx", int'(read_index), 0);
    chk("rst_state", int'(dut.state_q), int'(ARMED));
    chk("rst_addr", int'(write_address), 0);
    chk("rst_ws", int'(write_sample), 0);
    step(0, 1, 16'h0100, 0);
    chk("rst_prev_cleared", int'(write_enable), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 699) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
           ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
